// File: rtl/seq_shifter8_pkg.sv
// Shared types and helpers for the shifter8 datapath: op codes, FSM state codes,
// the per-bit 4:1 mux and the per-cycle step-size rule.
package seq_shifter8_pkg;

  localparam int WIDTH    = 8;
  localparam int MAX_STEP = 3;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic mux4(input logic [3:0] cand, input logic [1:0] sel);
    return cand[sel];
  endfunction

  function automatic logic [1:0] step_amt(input logic [2:0] rem);
    logic [2:0] cap;
    cap = 3'(MAX_STEP);
    return (rem > cap) ? cap[1:0] : rem[1:0];
  endfunction

endpackage

// File: rtl/seq_shifter8_step.sv
// Combinational 0..3-position shift step: one 4:1 mux per output bit, with the
// vacated positions filled by zero, the sign bit or the wrapped bits depending on op.
module shift_step8
  import seq_shifter8_pkg::*;
(
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       shamt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] d_out
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic [3:0] cand_s;
    for (genvar s = 0; s < 4; s++) begin : g_amt
      logic left_s;
      logic right_s;
      if (i - s >= 0) begin : g_left_in
        assign left_s = d_in[i-s];
      end else begin : g_left_fill
        assign left_s = 1'b0;
      end
      if (i + s <= 7) begin : g_right_in
        assign right_s = d_in[i+s];
      end else begin : g_right_fill
        assign right_s = (op == OP_ROR) ? d_in[i+s-8] :
                         (op == OP_ASR) ? d_in[7]     : 1'b0;
      end
      assign cand_s[s] = (op == OP_LSL) ? left_s : right_s;
    end
    assign d_out[i] = mux4(cand_s, shamt);
  end

endmodule

// File: rtl/seq_shifter8.sv
// Multi-cycle 8-bit shifter: accepts a request, iterates the 0..3 step stage until the
// full amount is applied, then holds the registered result until downstream accepts it.
module seq_shifter8
  import seq_shifter8_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_e           state_r;
  logic [WIDTH-1:0] data_r;
  logic [2:0]       rem_r;
  logic [1:0]       op_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [1:0]       step_s;
  logic [2:0]       rem_next_s;
  logic [WIDTH-1:0] step_data_s;

  assign step_s     = step_amt(rem_r);
  assign rem_next_s = rem_r - {1'b0, step_s};

  shift_step8 u_step (
    .d_in  (data_r),
    .shamt (step_s),
    .op    (op_r),
    .d_out (step_data_s)
  );

  // Handshake FSM with the operand/remaining-amount registers; flags are registered with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      data_r      <= 8'h00;
      rem_r       <= 3'd0;
      op_r        <= 2'b00;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r     <= in_data;
            rem_r      <= in_amt;
            op_r       <= in_op;
            in_ready_r <= 1'b0;
            if (in_amt == 3'd0) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_r <= step_data_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == 3'd0) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = data_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_seq_shifter8.sv
// Directed and scoreboarded bench for seq_shifter8 against an arithmetic shift reference.
module tb_seq_shifter8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_exp = 8'h00;
  bit         check_en = 1'b0;

  always #5 clk = ~clk;

  seq_shifter8 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Whole-amount reference shift using wide arithmetic.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic [1:0] op);
    logic [15:0] w;
    case (op)
      2'b00:   w = {8'h00, d} << amt;
      2'b01:   w = {8'h00, d} >> amt;
      2'b10:   w = {{8{d[7]}}, d} >> amt;
      default: w = {d, d} >> amt;
    endcase
    return w[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle a result is presented it must match the model's pending result.
  always @(negedge clk) begin
    if (check_en && out_valid) chk("out_data_vs_model", {24'h0, out_data}, {24'h0, model_exp});
  end

  // Issue a request right after an edge and wait for the result; checks latency and data.
  task automatic run_req(input logic [7:0] d, input int amt, input logic [1:0] op);
    int lat;
    model_exp = ref_shift(d, amt, op);
    chk("in_ready_before_req", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt[2:0];
    in_op    = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 1 + (amt + 2) / 3);
    chk("result", {24'h0, out_data}, {24'h0, model_exp});
  endtask

  task automatic finish_req();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", {31'h0, out_valid}, 32'h0);
    chk("in_ready_after_hs", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [7:0] held;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_op     = 2'b00;
    out_ready = 1'b0;

    // Pin the reference model itself.
    chk("pin_lsr_b5_5", {24'h0, ref_shift(8'hB5, 5, 2'b01)}, 32'h05);
    chk("pin_asr_80_7", {24'h0, ref_shift(8'h80, 7, 2'b10)}, 32'hFF);
    chk("pin_ror_81_1", {24'h0, ref_shift(8'h81, 1, 2'b11)}, 32'hC0);
    chk("pin_lsl_01_7", {24'h0, ref_shift(8'h01, 7, 2'b00)}, 32'h80);
    chk("pin_ror_5a_0", {24'h0, ref_shift(8'h5A, 0, 2'b11)}, 32'h5A);

    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_en = 1'b1;

    // Directed vectors with literal results.
    run_req(8'hB5, 5, 2'b01); chk("lit_lsr", {24'h0, out_data}, 32'h05); finish_req();
    run_req(8'h80, 7, 2'b10); chk("lit_asr", {24'h0, out_data}, 32'hFF); finish_req();
    run_req(8'h81, 1, 2'b11); chk("lit_ror", {24'h0, out_data}, 32'hC0); finish_req();
    run_req(8'h01, 7, 2'b00); chk("lit_lsl", {24'h0, out_data}, 32'h80); finish_req();
    run_req(8'h5A, 0, 2'b11); chk("lit_ror0", {24'h0, out_data}, 32'h5A); finish_req();

    // Backpressure, with an ignored request while DONE.
    run_req(8'h3C, 4, 2'b01);
    held = out_data;
    chk("lit_bp", {24'h0, held}, 32'h03);
    for (int k = 0; k < 4; k++) begin
      in_valid = (k == 1);
      in_data  = 8'hE7;
      in_amt   = 3'd2;
      in_op    = 2'b00;
      @(posedge clk); #1;
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_out_data", {24'h0, out_data}, {24'h0, held});
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    finish_req();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_not_queued", {31'h0, out_valid}, 32'h0);
      chk("bp_idle_ready", {31'h0, in_ready}, 32'h1);
    end

    // Reset in the second SHIFT cycle aborts the operation.
    model_exp = ref_shift(8'hFF, 7, 2'b00);
    in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7; in_op = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_out_data", {24'h0, out_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    run_req(8'h96, 3, 2'b10); chk("lit_after_abort", {24'h0, out_data}, 32'hF2); finish_req();

    // Back-to-back scoreboard over every op and amount.
    for (int op = 0; op < 4; op++) begin
      for (int amt = 0; amt < 8; amt++) begin
        run_req(8'($urandom_range(0, 255)), amt, 2'(op));
        finish_req();
      end
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
